// File: rtl/eth_pkg.sv
// Shared Ethernet/ARP constants, receive state encoding and byte helpers.
package eth_pkg;

  localparam logic [15:0] ETHERTYPE_ARP = 16'h0806;
  localparam logic [15:0] ARP_HTYPE     = 16'h0001;
  localparam logic [15:0] ARP_PTYPE     = 16'h0800;
  localparam logic [7:0]  ARP_HLEN      = 8'h06;
  localparam logic [7:0]  ARP_PLEN      = 8'h04;
  localparam logic [1:0]  ARP_OP_REQ    = 2'd1;
  localparam logic [1:0]  ARP_OP_REP    = 2'd2;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [7:0]  PREAMBLE      = 8'h55;
  localparam logic [7:0]  SFD           = 8'hD5;

  // Byte offsets (counted from the first byte after SFD) where each field starts.
  localparam int OFF_SRC   = 6;
  localparam int OFF_ETYPE = 12;
  localparam int OFF_HDR   = 14;
  localparam int OFF_SHA   = 22;
  localparam int OFF_SPA   = 28;
  localparam int OFF_THA   = 32;
  localparam int OFF_TPA   = 38;
  localparam int OFF_TAIL  = 42;

  typedef enum logic [3:0] {
    RX_IDLE, RX_PREAMBLE, RX_DST_MAC, RX_SRC_MAC, RX_ETHER_TYPE, RX_ARP_HEADER,
    RX_SHA, RX_SPA, RX_THA, RX_TPA, RX_TAIL, RX_DROP
  } rx_state_t;

  // One byte of reflected CRC32, data consumed LSB first.
  function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC32_POLY;
      else                c = c >> 1;
    end
    return c;
  endfunction

  // Expected fixed ARP header bytes 0..6 (htype, ptype, hlen, plen, oper MSB).
  function automatic logic [7:0] arp_hdr_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return ARP_HTYPE[15:8];
      3'd1:    return ARP_HTYPE[7:0];
      3'd2:    return ARP_PTYPE[15:8];
      3'd3:    return ARP_PTYPE[7:0];
      3'd4:    return ARP_HLEN;
      3'd5:    return ARP_PLEN;
      default: return 8'h00;
    endcase
  endfunction

  // Byte idx (0 = MSB) of a 48-bit MAC address.
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    logic [47:0] t;
    t = mac << {idx, 3'b000};
    return t[47:40];
  endfunction

  // Byte idx (0 = MSB) of a 32-bit IPv4 address.
  function automatic logic [7:0] ip_byte(input logic [31:0] ip, input logic [1:0] idx);
    logic [31:0] t;
    t = ip << {idx, 3'b000};
    return t[31:24];
  endfunction

endpackage

// File: rtl/crc32_rx_check.sv
// Running CRC32 over received bytes; flags when the register holds the good-frame residue.
module crc32_rx_check
  import eth_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_byte,
  input  logic       enable,
  input  logic       init,
  output logic       residue_ok
);

  logic [31:0] crc_r;

  // CRC register: init has priority, otherwise fold in each enabled byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      crc_r <= 32'hFFFFFFFF;
    else if (init)   crc_r <= 32'hFFFFFFFF;
    else if (enable) crc_r <= crc32_next(crc_r, data_byte);
    else             crc_r <= crc_r;
  end

  assign residue_ok = (crc_r == CRC32_RESIDUE);

endmodule

// File: rtl/arp_recv.sv
// ARP frame receiver: parses GMII bytes, filters, checks FCS and reports decoded fields.
module arp_recv
  import eth_pkg::*;
#(
  parameter int PRE_MIN    = 2,
  parameter int MIN_LEN    = 64,
  parameter int MAX_LEN    = 1518,
  parameter int FILTER_TPA = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_rx_dv,
  input  logic        i_rx_er,
  input  logic [7:0]  i_data,
  input  logic [47:0] i_my_mac,
  input  logic [31:0] i_my_ip,
  output logic        o_arp_valid,
  output logic [1:0]  o_operation,
  output logic [47:0] o_SHA,
  output logic [31:0] o_SPA,
  output logic [47:0] o_THA,
  output logic [31:0] o_TPA,
  output logic        o_crc_err,
  output logic        o_drop
);

  localparam int            CW      = $clog2(MAX_LEN + 2);
  localparam logic [CW-1:0] CNT_SAT = CW'(MAX_LEN + 1);

  rx_state_t     state_r, state_s, nxt_field_s;
  int            last_pos_s, pos_s;
  logic [CW-1:0] cnt_r, cnt_inc_s;
  logic [7:0]    pre_cnt_r;
  logic          mac_miss_r, bc_miss_r, rej_r, rej_all_s;
  logic [1:0]    op_r;
  logic [47:0]   sha_r, tha_r;
  logic [31:0]   spa_r, tpa_r;
  logic          in_frame_s, byte_s, eof_s, crc_ok_s, crc_init_s;
  logic          valid_s, crc_err_s, drop_s;

  assign in_frame_s = (state_r != RX_IDLE) && (state_r != RX_PREAMBLE) && (state_r != RX_DROP);
  assign byte_s     = in_frame_s & i_rx_dv & ~i_rx_er;
  assign eof_s      = in_frame_s & ~i_rx_dv;
  assign pos_s      = int'(cnt_r);
  assign cnt_inc_s  = (cnt_r == CNT_SAT) ? cnt_r : cnt_r + CW'(1);
  // Destination is rejected only if it matched neither our MAC nor broadcast.
  assign rej_all_s  = rej_r | (mac_miss_r & bc_miss_r);
  assign crc_init_s = (state_s == RX_IDLE);

  crc32_rx_check u_crc (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_byte  (i_data),
    .enable     (byte_s),
    .init       (crc_init_s),
    .residue_ok (crc_ok_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= RX_IDLE;
    else        state_r <= state_s;
  end

  // Last byte position of the current field and the field that follows it.
  always_comb begin
    last_pos_s  = -1;
    nxt_field_s = state_r;
    case (state_r)
      RX_DST_MAC:    begin last_pos_s = OFF_SRC - 1;   nxt_field_s = RX_SRC_MAC;    end
      RX_SRC_MAC:    begin last_pos_s = OFF_ETYPE - 1; nxt_field_s = RX_ETHER_TYPE; end
      RX_ETHER_TYPE: begin last_pos_s = OFF_HDR - 1;   nxt_field_s = RX_ARP_HEADER; end
      RX_ARP_HEADER: begin last_pos_s = OFF_SHA - 1;   nxt_field_s = RX_SHA;        end
      RX_SHA:        begin last_pos_s = OFF_SPA - 1;   nxt_field_s = RX_SPA;        end
      RX_SPA:        begin last_pos_s = OFF_THA - 1;   nxt_field_s = RX_THA;        end
      RX_THA:        begin last_pos_s = OFF_TPA - 1;   nxt_field_s = RX_TPA;        end
      RX_TPA:        begin last_pos_s = OFF_TAIL - 1;  nxt_field_s = RX_TAIL;       end
      default:       begin last_pos_s = -1;            nxt_field_s = state_r;       end
    endcase
  end

  // Next-state logic: framing, aborts and field sequencing.
  always_comb begin
    state_s = state_r;
    case (state_r)
      RX_IDLE: begin
        if (i_rx_dv && (i_data == PREAMBLE)) state_s = RX_PREAMBLE;
        else                                 state_s = RX_IDLE;
      end
      RX_PREAMBLE: begin
        if (!i_rx_dv)                                         state_s = RX_IDLE;
        else if (i_rx_er)                                     state_s = RX_DROP;
        else if (i_data == PREAMBLE)                          state_s = RX_PREAMBLE;
        else if ((i_data == SFD) && (int'(pre_cnt_r) >= PRE_MIN)) state_s = RX_DST_MAC;
        else                                                  state_s = RX_DROP;
      end
      RX_DROP: begin
        if (!i_rx_dv) state_s = RX_IDLE;
        else          state_s = RX_DROP;
      end
      RX_DST_MAC, RX_SRC_MAC, RX_ETHER_TYPE, RX_ARP_HEADER, RX_SHA,
      RX_SPA, RX_THA, RX_TPA, RX_TAIL: begin
        if (!i_rx_dv)                         state_s = RX_IDLE;
        else if (i_rx_er)                     state_s = RX_DROP;
        else if (int'(cnt_inc_s) > MAX_LEN)   state_s = RX_DROP;
        else if (pos_s == last_pos_s)         state_s = nxt_field_s;
        else                                  state_s = state_r;
      end
      default: state_s = RX_IDLE;
    endcase
  end

  // Result selection at end of frame, in priority: truncated, rejected, bad FCS, good.
  always_comb begin
    valid_s   = 1'b0;
    crc_err_s = 1'b0;
    drop_s    = 1'b0;
    if (eof_s) begin
      if ((state_r != RX_TAIL) || (pos_s < MIN_LEN)) drop_s    = 1'b1;
      else if (rej_all_s)                            drop_s    = 1'b1;
      else if (!crc_ok_s)                            crc_err_s = 1'b1;
      else                                           valid_s   = 1'b1;
    end else if ((state_r == RX_DROP) && !i_rx_dv) begin
      drop_s = 1'b1;
    end else begin
      drop_s = 1'b0;
    end
  end

  // Byte counter, preamble counter, field checks and shadow field registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= '0;
      pre_cnt_r  <= 8'd0;
      mac_miss_r <= 1'b0;
      bc_miss_r  <= 1'b0;
      rej_r      <= 1'b0;
      op_r       <= 2'd0;
      sha_r      <= 48'd0;
      spa_r      <= 32'd0;
      tha_r      <= 48'd0;
      tpa_r      <= 32'd0;
    end else if ((state_r == RX_IDLE) || (state_r == RX_PREAMBLE)) begin
      cnt_r      <= '0;
      mac_miss_r <= 1'b0;
      bc_miss_r  <= 1'b0;
      rej_r      <= 1'b0;
      if (state_r == RX_IDLE)
        pre_cnt_r <= 8'd1;
      else if (i_rx_dv && (i_data == PREAMBLE) && (pre_cnt_r != 8'hFF))
        pre_cnt_r <= pre_cnt_r + 8'd1;
    end else if (byte_s) begin
      cnt_r <= cnt_inc_s;
      if (pos_s < OFF_SRC) begin
        mac_miss_r <= mac_miss_r | (i_data != mac_byte(i_my_mac, 3'(pos_s)));
        bc_miss_r  <= bc_miss_r | (i_data != 8'hFF);
      end else if ((pos_s >= OFF_ETYPE) && (pos_s < OFF_HDR)) begin
        if (i_data != ((pos_s == OFF_ETYPE) ? ETHERTYPE_ARP[15:8] : ETHERTYPE_ARP[7:0]))
          rej_r <= 1'b1;
      end else if ((pos_s >= OFF_HDR) && (pos_s < OFF_SHA - 1)) begin
        if (i_data != arp_hdr_byte(3'(pos_s - OFF_HDR))) rej_r <= 1'b1;
      end else if (pos_s == OFF_SHA - 1) begin
        op_r <= i_data[1:0];
        if ((i_data != {6'd0, ARP_OP_REQ}) && (i_data != {6'd0, ARP_OP_REP})) rej_r <= 1'b1;
      end else if ((pos_s >= OFF_SHA) && (pos_s < OFF_SPA)) begin
        sha_r <= {sha_r[39:0], i_data};
      end else if ((pos_s >= OFF_SPA) && (pos_s < OFF_THA)) begin
        spa_r <= {spa_r[23:0], i_data};
      end else if ((pos_s >= OFF_THA) && (pos_s < OFF_TPA)) begin
        tha_r <= {tha_r[39:0], i_data};
      end else if ((pos_s >= OFF_TPA) && (pos_s < OFF_TAIL)) begin
        tpa_r <= {tpa_r[23:0], i_data};
        if ((FILTER_TPA != 0) && (i_data != ip_byte(i_my_ip, 2'(pos_s - OFF_TPA))))
          rej_r <= 1'b1;
      end
    end
  end

  // Registered result pulses; field outputs load only on an accepted frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_arp_valid <= 1'b0;
      o_crc_err   <= 1'b0;
      o_drop      <= 1'b0;
      o_operation <= 2'd0;
      o_SHA       <= 48'd0;
      o_SPA       <= 32'd0;
      o_THA       <= 48'd0;
      o_TPA       <= 32'd0;
    end else begin
      o_arp_valid <= valid_s;
      o_crc_err   <= crc_err_s;
      o_drop      <= drop_s;
      if (valid_s) begin
        o_operation <= op_r;
        o_SHA       <= sha_r;
        o_SPA       <= spa_r;
        o_THA       <= tha_r;
        o_TPA       <= tpa_r;
      end
    end
  end

endmodule

// File: tb/tb_arp_recv.sv
// Self-checking bench for arp_recv: directed frame table, corner sequences, random frames.
module tb_arp_recv;

  localparam logic [47:0] MY_MAC  = 48'h02_00_00_00_00_01;
  localparam logic [31:0] MY_IP   = 32'hC0A80102;
  localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;
  localparam logic [2:0]  R_VALID = 3'b100;
  localparam logic [2:0]  R_CRC   = 3'b010;
  localparam logic [2:0]  R_DROP  = 3'b001;

  logic clk = 1'b0, rst_n = 1'b0, rx_dv = 1'b0, rx_er = 1'b0;
  logic [7:0] data = 8'h00;
  logic        v1, c1, d1, v0, c0, d0;
  logic [1:0]  op1, op0;
  logic [47:0] sha1, tha1, sha0, tha0;
  logic [31:0] spa1, tpa1, spa0, tpa0;

  arp_recv #(.FILTER_TPA(1)) dut (
    .clk(clk), .rst_n(rst_n), .i_rx_dv(rx_dv), .i_rx_er(rx_er), .i_data(data),
    .i_my_mac(MY_MAC), .i_my_ip(MY_IP), .o_arp_valid(v1), .o_operation(op1),
    .o_SHA(sha1), .o_SPA(spa1), .o_THA(tha1), .o_TPA(tpa1), .o_crc_err(c1), .o_drop(d1)
  );

  arp_recv #(.FILTER_TPA(0)) dut_nf (
    .clk(clk), .rst_n(rst_n), .i_rx_dv(rx_dv), .i_rx_er(rx_er), .i_data(data),
    .i_my_mac(MY_MAC), .i_my_ip(MY_IP), .o_arp_valid(v0), .o_operation(op0),
    .o_SHA(sha0), .o_SPA(spa0), .o_THA(tha0), .o_TPA(tpa0), .o_crc_err(c0), .o_drop(d0)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pre_len; logic [47:0] dst; logic [15:0] etype; logic [15:0] oper;
    logic [47:0] sha; logic [31:0] spa; logic [47:0] tha; logic [31:0] tpa;
    int pad; int fcs_flip; int trunc; int er_pos;
  } frm_t;

  typedef struct { frm_t f; logic [2:0] e1; logic [2:0] e0; string name; } vec_t;

  int checks = 0, errors = 0;
  logic [31:0] crc_tbl [256];
  logic [7:0]  q [$];
  vec_t        vecs [$];
  // Expected held output fields: index 1 = filtering DUT, index 0 = non-filtering DUT.
  logic [1:0]  h_op [2];
  logic [47:0] h_sha [2], h_tha [2];
  logic [31:0] h_spa [2], h_tpa [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_held();
    for (int k = 0; k < 2; k++) begin
      h_op[k] = 2'd0; h_sha[k] = 48'd0; h_spa[k] = 32'd0; h_tha[k] = 48'd0; h_tpa[k] = 32'd0;
    end
  endtask

  // Assemble preamble + frame body + FCS (table CRC), then apply truncation.
  task automatic build(input frm_t f);
    logic [7:0]  body [$];
    logic [31:0] c, fcs;
    logic [47:0] src;
    logic [63:0] hdr;
    src = 48'h02AABBCCDDEE;
    hdr = {16'h0001, 16'h0800, 8'h06, 8'h04, f.oper};
    body = {};
    for (int i = 5; i >= 0; i--) body.push_back(f.dst[8*i +: 8]);
    for (int i = 5; i >= 0; i--) body.push_back(src[8*i +: 8]);
    body.push_back(f.etype[15:8]); body.push_back(f.etype[7:0]);
    for (int i = 7; i >= 0; i--) body.push_back(hdr[8*i +: 8]);
    for (int i = 5; i >= 0; i--) body.push_back(f.sha[8*i +: 8]);
    for (int i = 3; i >= 0; i--) body.push_back(f.spa[8*i +: 8]);
    for (int i = 5; i >= 0; i--) body.push_back(f.tha[8*i +: 8]);
    for (int i = 3; i >= 0; i--) body.push_back(f.tpa[8*i +: 8]);
    for (int i = 0; i < f.pad; i++) body.push_back(8'h00);
    c = 32'hFFFFFFFF;
    foreach (body[i]) c = (c >> 8) ^ crc_tbl[c[7:0] ^ body[i]];
    fcs = ~c;
    if (f.fcs_flip >= 0) fcs[f.fcs_flip] = ~fcs[f.fcs_flip];
    for (int i = 0; i < 4; i++) body.push_back(fcs[8*i +: 8]);
    if (f.trunc >= 0) while (body.size() > f.trunc) void'(body.pop_back());
    q = {};
    for (int i = 0; i < f.pre_len; i++) q.push_back(8'h55);
    q.push_back(8'hD5);
    foreach (body[i]) q.push_back(body[i]);
  endtask

  // Reference outcome from the frame description alone.
  function automatic logic [2:0] predict(input frm_t f, input int filter);
    int full, sent;
    logic rej;
    full = 46 + f.pad;
    sent = (f.trunc >= 0 && f.trunc < full) ? f.trunc : full;
    if (f.er_pos >= 0 && f.er_pos < sent) return R_DROP;
    if (f.pre_len < 2) return R_DROP;
    if (sent > 1518) return R_DROP;
    if (sent < 64) return R_DROP;
    rej = !(f.dst == MY_MAC || f.dst == BCAST) || (f.etype != 16'h0806) ||
          !(f.oper == 16'd1 || f.oper == 16'd2) || (filter != 0 && f.tpa != MY_IP);
    if (rej) return R_DROP;
    if (f.fcs_flip >= 0 || sent != full) return R_CRC;
    return R_VALID;
  endfunction

  task automatic check_fields(input string name);
    chk({name, "_op1"},  {62'd0, op1}, {62'd0, h_op[1]});
    chk({name, "_sha1"}, {16'd0, sha1}, {16'd0, h_sha[1]});
    chk({name, "_spa1"}, {32'd0, spa1}, {32'd0, h_spa[1]});
    chk({name, "_tha1"}, {16'd0, tha1}, {16'd0, h_tha[1]});
    chk({name, "_tpa1"}, {32'd0, tpa1}, {32'd0, h_tpa[1]});
    chk({name, "_op0"},  {62'd0, op0}, {62'd0, h_op[0]});
    chk({name, "_sha0"}, {16'd0, sha0}, {16'd0, h_sha[0]});
    chk({name, "_spa0"}, {32'd0, spa0}, {32'd0, h_spa[0]});
    chk({name, "_tha0"}, {16'd0, tha0}, {16'd0, h_tha[0]});
    chk({name, "_tpa0"}, {32'd0, tpa0}, {32'd0, h_tpa[0]});
  endtask

  // Drive one frame, then one idle cycle; result pulse is sampled one cycle after dv falls.
  task automatic run_frame(input frm_t f, input logic [2:0] e1, input logic [2:0] e0, input string name);
    int spur;
    logic [2:0] r1, r0;
    build(f);
    spur = 0;
    for (int i = 0; i < q.size(); i++) begin
      rx_dv = 1'b1;
      data  = q[i];
      rx_er = (f.er_pos >= 0) && (i == f.pre_len + 1 + f.er_pos);
      @(negedge clk);
      if ({v1, c1, d1, v0, c0, d0} != 6'd0) spur++;
    end
    rx_dv = 1'b0; rx_er = 1'b0; data = 8'h00;
    @(negedge clk);
    r1 = {v1, c1, d1};
    r0 = {v0, c0, d0};
    chk({name, "_spurious"}, spur, 0);
    chk({name, "_res_filt"}, {61'd0, r1}, {61'd0, e1});
    chk({name, "_res_nofilt"}, {61'd0, r0}, {61'd0, e0});
    if (e1 == R_VALID) begin
      h_op[1] = f.oper[1:0]; h_sha[1] = f.sha; h_spa[1] = f.spa; h_tha[1] = f.tha; h_tpa[1] = f.tpa;
    end
    if (e0 == R_VALID) begin
      h_op[0] = f.oper[1:0]; h_sha[0] = f.sha; h_spa[0] = f.spa; h_tha[0] = f.tha; h_tpa[0] = f.tpa;
    end
    check_fields(name);
  endtask

  task automatic add_vec(input frm_t f, input logic [2:0] e1, input logic [2:0] e0, input string name);
    vec_t v;
    v.f = f; v.e1 = e1; v.e0 = e0; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic count_pulses(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if ({v1, c1, d1, v0, c0, d0} != 6'd0) n++;
    end
  endtask

  initial begin
    frm_t g, rp, f;
    int n, r;

    for (int k = 0; k < 256; k++) begin
      logic [31:0] c;
      c = 32'(k);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tbl[k] = c;
    end
    clear_held();

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset_pulses", {58'd0, v1, c1, d1, v0, c0, d0}, 64'd0);
    check_fields("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // dv burst that never looks like a preamble: no pulse.
    rx_dv = 1'b1; data = 8'h12;
    count_pulses(5, n);
    rx_dv = 1'b0;
    count_pulses(3, r);
    chk("idle_burst_silent", n + r, 0);

    // dv falls during preamble: silent return.
    rx_dv = 1'b1; data = 8'h55;
    count_pulses(3, n);
    rx_dv = 1'b0;
    count_pulses(3, r);
    chk("preamble_abort_silent", n + r, 0);

    g = '{pre_len: 7, dst: BCAST, etype: 16'h0806, oper: 16'd1, sha: 48'h001122334455,
          spa: 32'hC0A8010A, tha: 48'h0, tpa: MY_IP, pad: 18, fcs_flip: -1, trunc: -1, er_pos: -1};
    rp = g; rp.oper = 16'd2; rp.dst = MY_MAC; rp.sha = 48'hAABBCCDDEEFF;
    rp.spa = 32'hC0A80114; rp.tha = MY_MAC;

    add_vec(g, R_VALID, R_VALID, "bcast_req");
    f = g; f.fcs_flip = 3;        add_vec(f, R_CRC, R_CRC, "fcs_flip");
    f = g; f.dst = 48'h020000000099; add_vec(f, R_DROP, R_DROP, "foreign_mac");
    f = g; f.etype = 16'h0800;    add_vec(f, R_DROP, R_DROP, "ethertype_ip");
    f = g; f.trunc = 32;          add_vec(f, R_DROP, R_DROP, "trunc_after_spa");
    add_vec(rp, R_VALID, R_VALID, "reply_after_trunc");
    f = rp; f.er_pos = 34;        add_vec(f, R_DROP, R_DROP, "rx_er_in_tha");
    f = rp; f.spa = 32'hC0A80115; add_vec(f, R_VALID, R_VALID, "b2b_reply_a");
    f = rp; f.spa = 32'hC0A80116; add_vec(f, R_VALID, R_VALID, "b2b_reply_b");
    f = g; f.tpa = 32'hC0A80163; f.sha = 48'h0A0B0C0D0E0F;
    add_vec(f, R_DROP, R_VALID, "foreign_tpa");
    f = g; f.pad = 17;            add_vec(f, R_DROP, R_DROP, "len_63");
    f = g; f.pre_len = 1;         add_vec(f, R_DROP, R_DROP, "preamble_1");
    f = g; f.pre_len = 2; f.spa = 32'hC0A80120; add_vec(f, R_VALID, R_VALID, "preamble_2");
    f = g; f.oper = 16'd3;        add_vec(f, R_DROP, R_DROP, "oper_3");
    f = g; f.pad = 1472; f.spa = 32'hC0A80130; add_vec(f, R_VALID, R_VALID, "len_1518");
    f = g; f.pad = 1473;          add_vec(f, R_DROP, R_DROP, "len_1519");

    foreach (vecs[i]) run_frame(vecs[i].f, vecs[i].e1, vecs[i].e0, vecs[i].name);

    // Reset in the middle of a frame: no pulse, fields cleared, next frame accepted.
    build(g);
    for (int i = 0; i < 20; i++) begin
      rx_dv = 1'b1; data = q[i];
      @(negedge clk);
    end
    rst_n = 1'b0;
    rx_dv = 1'b0; data = 8'h00;
    count_pulses(2, n);
    rst_n = 1'b1;
    count_pulses(3, r);
    chk("midframe_reset_silent", n + r, 0);
    clear_held();
    check_fields("midframe_reset");
    run_frame(rp, R_VALID, R_VALID, "after_reset");

    // Random frames against the reference outcome.
    for (int t = 0; t < 40; t++) begin
      f.pre_len = int'($urandom_range(1, 8));
      r = int'($urandom_range(0, 3));
      f.dst = (r == 0) ? BCAST : (r == 3) ? {16'h0200, $urandom} : MY_MAC;
      f.etype = ($urandom_range(0, 7) == 0) ? 16'h0800 : 16'h0806;
      r = int'($urandom_range(0, 9));
      f.oper = (r < 4) ? 16'd1 : (r < 8) ? 16'd2 : (r == 8) ? 16'd0 : 16'd3;
      f.sha = {16'($urandom), $urandom};
      f.spa = $urandom;
      f.tha = {16'($urandom), $urandom};
      f.tpa = ($urandom_range(0, 3) == 0) ? $urandom : MY_IP;
      f.pad = int'($urandom_range(0, 40));
      f.fcs_flip = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 31)) : -1;
      f.trunc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 46 + f.pad)) : -1;
      f.er_pos = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 45 + f.pad)) : -1;
      run_frame(f, predict(f, 1), predict(f, 0), $sformatf("rand%0d", t));
    end

    count_pulses(3, n);
    chk("final_idle_silent", n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
